gpr_writeback_queue: RTL
========================

Name: gpr_writeback_queue

Overview:
- Writeback-side producer for the 8x16 general-purpose register file write port (reg_write_en / reg_write_dest / reg_write_data).
- Accepts results from the ALU and the memory-load path over valid/ready handshakes and buffers them in an in-order FIFO.
- Drains at most one write per cycle into the register file, and can be frozen by a stall input.
- Exposes a pending-write mask and a forwarding lookup so decode can detect and bypass in-flight writes.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 3, register address width (2**ADDR_W registers)
- DEPTH, 4, FIFO entries; power of two, >=2

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_valid  in  1  load result valid
- mem_ready  out  1  load result accepted
- mem_dest  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU result accepted
- alu_dest  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU data
- wb_stall  in  1  freeze draining
- reg_write_en  out  1  register file write enable (registered)
- reg_write_dest  out  ADDR_W  register file write address (registered)
- reg_write_data  out  DATA_W  register file write data (registered)
- pending_mask  out  2**ADDR_W  bit i = a write to register i is queued or being presented
- fwd_addr  in  ADDR_W  forwarding lookup address
- fwd_hit  out  1  lookup matched an in-flight write
- fwd_data  out  DATA_W  youngest in-flight data for fwd_addr
- count  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, count=0, reg_write_en=0, reg_write_dest=0, reg_write_data=0. pending_mask=0 and fwd_hit=0. mem_ready and alu_ready are forced 0 while rst_n is low.
- Ready rules (combinational from current state):
  - mem_ready = (count != DEPTH).
  - alu_ready = (count != DEPTH) && !mem_valid.
  - A full FIFO never accepts, even if it pops in the same cycle.
- Enqueue: at most one per edge. mem has fixed priority; ALU is accepted only when mem_valid=0. An accepted item is pushed at the tail on that edge.
- Drain (each edge, after deassertion):
  - If wb_stall=0 and count>0: head is popped into the output registers and reg_write_en<=1.
  - Otherwise reg_write_en<=0, and dest/data hold their previous values.
  - The register file consumes the presented write on the next edge, regardless of wb_stall.
- Latency: accepted on edge N → reg_write_en high during cycle N+1..N+2 → register written on edge N+2. Sustained throughput is 1 write/cycle.
- Count: next = count + push - pop; simultaneous push and pop leaves count unchanged. Read/write pointers wrap modulo DEPTH.
- Ordering: strict FIFO order across both sources. Multiple queued writes to the same register are applied oldest first, so the last write wins.
- pending_mask: OR over valid FIFO entries of onehot(dest), ORed with onehot(reg_write_dest) when reg_write_en=1. Combinational.
- Forwarding (combinational):
  - Search valid FIFO entries youngest to oldest, then the output register if reg_write_en=1. First match gives fwd_hit=1 and fwd_data = that entry's data.
  - No match gives fwd_hit=0 and fwd_data=0.
  - Items being enqueued in the current cycle are not visible.
- No register is special; writes to register 0 are queued like any other.
- Reset mid-operation: all queued and presented writes are discarded immediately and reg_write_en drops asynchronously.

Test Plan:
- Reset, then idle → all outputs 0, mem_ready=1, alu_ready=1. Single ALU push dest=3, data=0x1234 on edge N → reg_write_en=1, dest=3, data=0x1234 in cycle after edge N+1; pending_mask=0x08 from after N until after N+2.
- mem_valid and alu_valid both high (mem dest=1/0xAAAA, alu dest=2/0x5555) → alu_ready=0. mem write emerges first; ALU accepted on the next cycle and emerges one cycle later.
- wb_stall=1, push 4 ALU items (dest 0..3, data 0x10..0x13) → count=4, mem_ready=alu_ready=0, reg_write_en=0. Release stall → writes 0x10,0x11,0x12,0x13 on 4 consecutive cycles, then count=0.
- Stalled, queue dest=5/0x0001 then dest=5/0x0002, set fwd_addr=5 → fwd_hit=1, fwd_data=0x0002. fwd_addr=6 → fwd_hit=0, fwd_data=0.
- Full FIFO with stall released and alu_valid=1 in the same cycle → no accept that edge (count 4→3), accept the next edge.
- Pull rst_n low mid-cycle with 3 items queued and reg_write_en=1 → reg_write_en, count, pending_mask go to 0 immediately. After release, no stale writes appear.

Source files
------------

// File: rtl/gpr_writeback_queue.sv
// gpr_writeback_queue: in-order writeback buffer feeding the 8x16 GPR write port.
// Load results have fixed priority over ALU results. Writes drain one per cycle
// through registered outputs and can be frozen by wb_stall. A pending-write
// mask and a youngest-first forwarding lookup let decode see in-flight writes.
module gpr_writeback_queue #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDR_W-1:0]        mem_dest,
    input  logic [DATA_W-1:0]        mem_data,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_dest,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     wb_stall,
    output logic                     reg_write_en,
    output logic [ADDR_W-1:0]        reg_write_dest,
    output logic [DATA_W-1:0]        reg_write_data,
    output logic [(1<<ADDR_W)-1:0]   pending_mask,
    input  logic [ADDR_W-1:0]        fwd_addr,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 1 << ADDR_W;

    // FIFO storage and pointers
    logic [ADDR_W-1:0] dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Presented write-port registers
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] wdest_q, wdest_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // Handshake and datapath selects
    logic              full_s;
    logic              push_s;
    logic              pop_s;
    logic [ADDR_W-1:0] push_dest_s;
    logic [DATA_W-1:0] push_data_s;

    // Lookup results
    logic [NREG-1:0]   pending_s;
    logic              hit_s;
    logic [DATA_W-1:0] fdata_s;

    // A full FIFO refuses new work even when it pops on the same edge; ready is
    // held low while reset is asserted.
    assign full_s    = (count_q == CNT_W'(DEPTH));
    assign mem_ready = rst_n & ~full_s;
    assign alu_ready = rst_n & ~full_s & ~mem_valid;
    assign push_s    = (mem_valid & mem_ready) | (alu_valid & alu_ready);
    assign pop_s     = ~wb_stall & (count_q != {CNT_W{1'b0}});

    // Select the source of the enqueued item: load path wins when valid
    always_comb begin
        push_dest_s = alu_dest;
        push_data_s = alu_data;
        if (mem_valid) begin
            push_dest_s = mem_dest;
            push_data_s = mem_data;
        end else begin
            push_dest_s = alu_dest;
            push_data_s = alu_data;
        end
    end

    // Next-state for pointers, occupancy and the presented write
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        wen_d    = 1'b0;
        wdest_d  = wdest_q;
        wdata_d  = wdata_q;
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            wen_d    = 1'b1;
            wdest_d  = dest_q[rd_ptr_q];
            wdata_d  = data_q[rd_ptr_q];
        end else begin
            wen_d    = 1'b0;
        end
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and output registers; reset discards every queued and presented write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            wen_q    <= 1'b0;
            wdest_q  <= {ADDR_W{1'b0}};
            wdata_q  <= {DATA_W{1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            wen_q    <= wen_d;
            wdest_q  <= wdest_d;
            wdata_q  <= wdata_d;
        end
    end

    // FIFO entry storage, written at the tail on an accepted push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i] <= {ADDR_W{1'b0}};
                data_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_s && (wr_ptr_q == PTR_W'(i))) begin
                    dest_q[i] <= push_dest_s;
                    data_q[i] <= push_data_s;
                end else begin
                    dest_q[i] <= dest_q[i];
                    data_q[i] <= data_q[i];
                end
            end
        end
    end

    // Pending mask and forwarding: walk presented write, then FIFO oldest to
    // youngest so that the youngest matching entry is the one left standing
    always_comb begin
        pending_s = {NREG{1'b0}};
        hit_s     = 1'b0;
        fdata_s   = {DATA_W{1'b0}};
        pending_s = pending_s | ({NREG{wen_q}} & ({{(NREG-1){1'b0}}, 1'b1} << wdest_q));
        hit_s     = wen_q & (wdest_q == fwd_addr);
        fdata_s   = hit_s ? wdata_q : fdata_s;
        for (int i = 0; i < DEPTH; i++) begin
            pending_s = pending_s |
                ({NREG{CNT_W'(i) < count_q}} &
                 ({{(NREG-1){1'b0}}, 1'b1} << dest_q[rd_ptr_q + PTR_W'(i)]));
            fdata_s = ((CNT_W'(i) < count_q) && (dest_q[rd_ptr_q + PTR_W'(i)] == fwd_addr))
                      ? data_q[rd_ptr_q + PTR_W'(i)] : fdata_s;
            hit_s   = hit_s |
                      ((CNT_W'(i) < count_q) && (dest_q[rd_ptr_q + PTR_W'(i)] == fwd_addr));
        end
    end

    assign reg_write_en   = wen_q;
    assign reg_write_dest = wdest_q;
    assign reg_write_data = wdata_q;
    assign pending_mask   = pending_s;
    assign fwd_hit        = hit_s;
    assign fwd_data       = fdata_s;
    assign count          = count_q;

endmodule
